not_pipe_bank: RTL

//   Parametrised, pipelined bank of WIDTH inverters with a per-bit polarity mask.
//   A bit inverts where its mask bit is 1 and passes through where it is 0.

---
 rtl/not_pipe_bank.sv | 92 +++++++++
 1 files changed

// File: rtl/not_pipe_bank.sv
// not_pipe_bank: pipelined bank of WIDTH inverters with a programmable
// per-bit polarity mask and valid/ready handshakes on both sides.
// A bit inverts where the mask is 1 and passes through where it is 0.
// The transform happens when a beat enters stage 1; later stages only
// move data forward, so a mask change never touches beats already inside.

module not_pipe_bank #(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 2,
    parameter logic [WIDTH-1:0] RESET_MASK = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mask_wr,
    input  logic [WIDTH-1:0] mask_in,
    output logic [WIDTH-1:0] mask_out,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    logic [WIDTH-1:0] mask;
    logic [DEPTH:1]   vld;
    logic [WIDTH-1:0] dat [1:DEPTH];

    logic [DEPTH:1]   can_load;
    logic [DEPTH:1]   src_vld;
    logic [WIDTH-1:0] src_dat [1:DEPTH];

    // Ready chain from the output back to the input: a stage can load when it
    // is empty or when its own content moves on during this cycle.
    always_comb begin : ready_chain
        logic run;
        can_load = '0;
        run = !vld[DEPTH] || out_ready;
        can_load[DEPTH] = run;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            run = !vld[k] || run;
            can_load[k] = run;
        end
    end

    // What each stage would load: stage 1 takes the masked input, the rest
    // take the previous stage unchanged.
    always_comb begin
        src_vld = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            src_dat[k] = '0;
        end
        src_vld[1] = in_valid;
        src_dat[1] = in_data ^ mask;
        for (int k = 2; k <= DEPTH; k++) begin
            src_vld[k] = vld[k-1];
            src_dat[k] = dat[k-1];
        end
    end

    // Mask register and pipeline stages. Data only updates when a real beat
    // arrives, so bubbles leave the stage contents (and out_data) untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= RESET_MASK;
            vld  <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                dat[k] <= '0;
            end
        end else begin
            if (mask_wr) begin
                mask <= mask_in;
            end
            for (int k = 1; k <= DEPTH; k++) begin
                if (can_load[k]) begin
                    vld[k] <= src_vld[k];
                    if (src_vld[k]) begin
                        dat[k] <= src_dat[k];
                    end
                end
            end
        end
    end

    assign in_ready  = can_load[1];
    assign out_valid = vld[DEPTH];
    assign out_data  = dat[DEPTH];
    assign busy      = |vld;
    assign mask_out  = mask;

endmodule
